// File: rtl/iq_sweep_ctrl_if.sv
// Result handshake between the sweep controller and its consumer:
// one accumulated I/Q pair per sweep point.
interface iq_sweep_ctrl_if #(
    parameter int unsigned OUTPUT_WIDTH = 12,
    parameter int unsigned CNT_WIDTH    = 16
);
    logic                                 res_valid;
    logic                                 res_ready;
    logic signed [OUTPUT_WIDTH+CNT_WIDTH-1:0] res_I;
    logic signed [OUTPUT_WIDTH+CNT_WIDTH-1:0] res_Q;
    logic [CNT_WIDTH-1:0]                 res_idx;

    modport master (output res_valid, res_I, res_Q, res_idx, input res_ready);
    modport slave  (input res_valid, res_I, res_Q, res_idx, output res_ready);
endinterface

// File: rtl/iq_sweep_ctrl.sv
// Frequency-sweep sequencer: retunes the mixer per point, waits for settling,
// accumulates I/Q samples and hands each point's sums out over a valid/ready port.
module iq_sweep_ctrl #(
    parameter int unsigned PHASE_WIDTH  = 32,
    parameter int unsigned OUTPUT_WIDTH = 12,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                           clk_in,
    input  logic                           RST_n,
    input  logic                           start,
    input  logic                           abort,
    input  logic [PHASE_WIDTH-1:0]         f_start,
    input  logic [PHASE_WIDTH-1:0]         f_step,
    input  logic [CNT_WIDTH-1:0]           n_points,
    input  logic [CNT_WIDTH-1:0]           settle_cyc,
    input  logic [CNT_WIDTH-1:0]           acq_len,
    output logic [PHASE_WIDTH-1:0]         Fre_word,
    input  logic                           iq_valid,
    input  logic signed [OUTPUT_WIDTH-1:0] I_in,
    input  logic signed [OUTPUT_WIDTH-1:0] Q_in,
    output logic                           busy,
    output logic                           done,
    iq_sweep_ctrl_if.master                res
);
    localparam int unsigned AccWidth = OUTPUT_WIDTH + CNT_WIDTH;

    typedef enum logic [2:0] {StIdle, StTune, StSettle, StAcq, StReport, StDone} state_e;

    state_e                     state_q;
    logic [PHASE_WIDTH-1:0]     f_start_q, f_step_q, fre_word_q;
    logic [CNT_WIDTH-1:0]       n_points_q, settle_q, acq_len_q;
    logic [CNT_WIDTH-1:0]       idx_q, settle_cnt_q, acq_cnt_q;
    logic signed [AccWidth-1:0] acc_i_q, acc_q_q;
    logic                       res_valid_q, busy_q, done_q;

    logic [CNT_WIDTH-1:0]       acq_target;
    logic                       settle_last, acq_last, point_last;
    logic signed [AccWidth-1:0] i_ext, q_ext;

    // acq_len of zero still takes one sample per point
    assign acq_target  = (acq_len_q == '0) ? CNT_WIDTH'(1) : acq_len_q;
    assign settle_last = (settle_q == '0) || (settle_cnt_q == settle_q - CNT_WIDTH'(1));
    assign acq_last    = (acq_cnt_q == acq_target - CNT_WIDTH'(1));
    assign point_last  = (idx_q == n_points_q - CNT_WIDTH'(1));
    assign i_ext       = {{CNT_WIDTH{I_in[OUTPUT_WIDTH-1]}}, I_in};
    assign q_ext       = {{CNT_WIDTH{Q_in[OUTPUT_WIDTH-1]}}, Q_in};

    always_ff @(posedge clk_in or negedge RST_n) begin
        if (!RST_n) begin
            state_q      <= StIdle;
            f_start_q    <= '0;
            f_step_q     <= '0;
            fre_word_q   <= '0;
            n_points_q   <= '0;
            settle_q     <= '0;
            acq_len_q    <= '0;
            idx_q        <= '0;
            settle_cnt_q <= '0;
            acq_cnt_q    <= '0;
            acc_i_q      <= '0;
            acc_q_q      <= '0;
            res_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else if (abort) begin
            // Tuning word and accumulators are left as they are
            state_q     <= StIdle;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start && (n_points != '0)) begin
                        f_start_q  <= f_start;
                        f_step_q   <= f_step;
                        n_points_q <= n_points;
                        settle_q   <= settle_cyc;
                        acq_len_q  <= acq_len;
                        idx_q      <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= StTune;
                    end
                end
                StTune: begin
                    fre_word_q   <= (idx_q == '0) ? f_start_q : fre_word_q + f_step_q;
                    acc_i_q      <= '0;
                    acc_q_q      <= '0;
                    acq_cnt_q    <= '0;
                    settle_cnt_q <= '0;
                    state_q      <= StSettle;
                end
                StSettle: begin
                    if (settle_last) begin
                        state_q <= StAcq;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + CNT_WIDTH'(1);
                    end
                end
                StAcq: begin
                    if (iq_valid) begin
                        acc_i_q   <= acc_i_q + i_ext;
                        acc_q_q   <= acc_q_q + q_ext;
                        acq_cnt_q <= acq_cnt_q + CNT_WIDTH'(1);
                        if (acq_last) begin
                            res_valid_q <= 1'b1;
                            state_q     <= StReport;
                        end
                    end
                end
                StReport: begin
                    if (res.res_ready) begin
                        res_valid_q <= 1'b0;
                        if (point_last) begin
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            idx_q   <= idx_q + CNT_WIDTH'(1);
                            state_q <= StTune;
                        end
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign Fre_word      = fre_word_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign res.res_valid = res_valid_q;
    assign res.res_I     = acc_i_q;
    assign res.res_Q     = acc_q_q;
    assign res.res_idx   = idx_q;
endmodule

// File: tb/tb_iq_sweep_ctrl.sv
// Self-checking bench for iq_sweep_ctrl: expected per-point results are queued
// at start time and popped on each result handshake.
module tb_iq_sweep_ctrl;
    localparam int PW = 32;
    localparam int OW = 12;
    localparam int CW = 16;
    localparam int AW = OW + CW;

    logic                 clk_in = 1'b0;
    logic                 RST_n  = 1'b1;
    logic                 start  = 1'b0;
    logic                 abort  = 1'b0;
    logic [PW-1:0]        f_start = '0;
    logic [PW-1:0]        f_step  = '0;
    logic [CW-1:0]        n_points = '0;
    logic [CW-1:0]        settle_cyc = '0;
    logic [CW-1:0]        acq_len = '0;
    logic [PW-1:0]        Fre_word;
    logic                 iq_valid = 1'b1;
    logic signed [OW-1:0] I_in = '0;
    logic signed [OW-1:0] Q_in = '0;
    logic                 busy;
    logic                 done;

    iq_sweep_ctrl_if #(.OUTPUT_WIDTH(OW), .CNT_WIDTH(CW)) res_if ();

    iq_sweep_ctrl #(.PHASE_WIDTH(PW), .OUTPUT_WIDTH(OW), .CNT_WIDTH(CW)) dut (
        .clk_in     (clk_in),
        .RST_n      (RST_n),
        .start      (start),
        .abort      (abort),
        .f_start    (f_start),
        .f_step     (f_step),
        .n_points   (n_points),
        .settle_cyc (settle_cyc),
        .acq_len    (acq_len),
        .Fre_word   (Fre_word),
        .iq_valid   (iq_valid),
        .I_in       (I_in),
        .Q_in       (Q_in),
        .busy       (busy),
        .done       (done),
        .res        (res_if)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [CW-1:0]        idx;
        logic signed [AW-1:0] i;
        logic signed [AW-1:0] q;
        logic [PW-1:0]        fre;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic setup(input logic [PW-1:0] fs, input logic [PW-1:0] fst,
                         input logic [CW-1:0] np, input logic [CW-1:0] sc,
                         input logic [CW-1:0] al, input int iv, input int qv);
        f_start    = fs;
        f_step     = fst;
        n_points   = np;
        settle_cyc = sc;
        acq_len    = al;
        I_in       = OW'(iv);
        Q_in       = OW'(qv);
    endtask

    task automatic push_points(input logic [PW-1:0] fs, input logic [PW-1:0] fst,
                               input int np, input int al, input int iv, input int qv);
        logic [PW-1:0] f;
        int            len;
        exp_t          e;
        f   = fs;
        len = (al == 0) ? 1 : al;
        for (int k = 0; k < np; k++) begin
            e.idx = CW'(k);
            e.i   = AW'(iv * len);
            e.q   = AW'(qv * len);
            e.fre = f;
            sb.push_back(e);
            f = f + fst;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
    endtask

    task automatic check_handshake(input string tag);
        exp_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL %s unexpected result: idx=%0d, none required", tag, res_if.res_idx);
        end else begin
            e = sb.pop_front();
            if (res_if.res_idx !== e.idx) begin
                n_err++;
                $display("FAIL %s res_idx: got %0d required %0d", tag, res_if.res_idx, e.idx);
            end
            n_vec++;
            if (res_if.res_I !== e.i) begin
                n_err++;
                $display("FAIL %s res_I[%0d]: got %0d required %0d", tag, e.idx, res_if.res_I, e.i);
            end
            n_vec++;
            if (res_if.res_Q !== e.q) begin
                n_err++;
                $display("FAIL %s res_Q[%0d]: got %0d required %0d", tag, e.idx, res_if.res_Q, e.q);
            end
            n_vec++;
            if (Fre_word !== e.fre) begin
                n_err++;
                $display("FAIL %s Fre_word[%0d]: got %h required %h", tag, e.idx, Fre_word, e.fre);
            end
        end
    endtask

    // Runs from the current negedge until done with an empty scoreboard, or budget expires
    task automatic run_and_check(input string tag, input int budget);
        int dones = 0;
        int cyc   = 0;
        bit fin   = 1'b0;
        while (!fin && cyc < budget) begin
            if (res_if.res_valid && res_if.res_ready) check_handshake(tag);
            if (done) begin
                dones++;
                if (sb.size() == 0) fin = 1'b1;
            end
            if (!fin) begin
                @(negedge clk_in);
                cyc++;
            end
        end
        n_vec++;
        if (!fin) begin
            n_err++;
            $display("FAIL %s timeout: got %0d results pending, required 0 and done", tag, sb.size());
            sb.delete();
        end
        n_vec++;
        if (dones !== 1) begin
            n_err++;
            $display("FAIL %s done pulses: got %0d required 1", tag, dones);
        end
        @(negedge clk_in);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL %s after done: got busy=%b done=%b required 0 0", tag, busy, done);
        end
    endtask

    task automatic check_all_zero(input string tag);
        n_vec++;
        if (Fre_word !== '0 || res_if.res_I !== '0 || res_if.res_Q !== '0 ||
            res_if.res_idx !== '0 || res_if.res_valid !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0) begin
            n_err++;
            $display("FAIL %s outputs: got fre=%h I=%0d Q=%0d idx=%0d v=%b busy=%b done=%b required all 0",
                     tag, Fre_word, res_if.res_I, res_if.res_Q, res_if.res_idx,
                     res_if.res_valid, busy, done);
        end
    endtask

    task automatic test_reset();
        res_if.res_ready = 1'b1;
        #2 RST_n = 1'b0;
        #1 check_all_zero("reset");
        @(negedge clk_in);
        @(negedge clk_in);
        RST_n = 1'b1;
    endtask

    task automatic test_basic();
        setup(32'h1000_0000, 32'h0100_0000, 16'd3, 16'd4, 16'd2, 5, -3);
        res_if.res_ready = 1'b1;
        push_points(32'h1000_0000, 32'h0100_0000, 3, 2, 5, -3);
        pulse_start();
        run_and_check("basic", 200);
    endtask

    task automatic test_wrap();
        setup(32'hFFFF_FF00, 32'h0000_0200, 16'd2, 16'd1, 16'd1, 5, -3);
        push_points(32'hFFFF_FF00, 32'h0000_0200, 2, 1, 5, -3);
        pulse_start();
        run_and_check("wrap", 200);
    endtask

    task automatic test_backpressure();
        int cyc = 0;
        setup(32'h2000_0000, 32'h0000_0010, 16'd2, 16'd0, 16'd2, 7, 1);
        res_if.res_ready = 1'b0;
        push_points(32'h2000_0000, 32'h0000_0010, 2, 2, 7, 1);
        pulse_start();
        while (!res_if.res_valid && cyc < 50) begin
            @(negedge clk_in);
            cyc++;
        end
        for (int k = 0; k < 20; k++) begin
            n_vec++;
            if (res_if.res_valid !== 1'b1 || res_if.res_I !== 28'sd14 || res_if.res_Q !== 28'sd2 ||
                res_if.res_idx !== 16'd0 || Fre_word !== 32'h2000_0000) begin
                n_err++;
                $display("FAIL stall[%0d]: got v=%b I=%0d Q=%0d idx=%0d fre=%h required 1 14 2 0 20000000",
                         k, res_if.res_valid, res_if.res_I, res_if.res_Q, res_if.res_idx, Fre_word);
            end
            I_in = OW'($urandom);
            Q_in = OW'($urandom);
            @(negedge clk_in);
        end
        I_in = 12'sd7;
        Q_in = 12'sd1;
        res_if.res_ready = 1'b1;
        run_and_check("stall", 200);
    endtask

    task automatic test_npoints_zero();
        setup(32'h1234_0000, 32'h1, 16'd0, 16'd1, 16'd1, 1, 1);
        pulse_start();
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (busy !== 1'b0 || res_if.res_valid !== 1'b0) begin
                n_err++;
                $display("FAIL npoints0[%0d]: got busy=%b valid=%b required 0 0",
                         k, busy, res_if.res_valid);
            end
            @(negedge clk_in);
        end
    endtask

    task automatic test_zero_len();
        setup(32'h0300_0000, 32'h0030_0000, 16'd3, 16'd0, 16'd0, -100, 50);
        push_points(32'h0300_0000, 32'h0030_0000, 3, 0, -100, 50);
        pulse_start();
        run_and_check("zerolen", 200);
    endtask

    task automatic test_abort();
        setup(32'h0A00_0000, 32'h0100_0000, 16'd3, 16'd10, 16'd2, 5, -3);
        pulse_start();
        @(negedge clk_in);
        @(negedge clk_in);
        n_vec++;
        if (busy !== 1'b1 || Fre_word !== 32'h0A00_0000) begin
            n_err++;
            $display("FAIL abort pre: got busy=%b fre=%h required 1 0a000000", busy, Fre_word);
        end
        abort = 1'b1;
        @(negedge clk_in);
        abort = 1'b0;
        for (int k = 0; k < 10; k++) begin
            n_vec++;
            if (busy !== 1'b0 || done !== 1'b0 || res_if.res_valid !== 1'b0 ||
                Fre_word !== 32'h0A00_0000) begin
                n_err++;
                $display("FAIL abort[%0d]: got busy=%b done=%b valid=%b fre=%h required 0 0 0 0a000000",
                         k, busy, done, res_if.res_valid, Fre_word);
            end
            @(negedge clk_in);
        end
    endtask

    task automatic test_reset_mid();
        int  cyc = 0;
        bit  seen = 1'b0;
        setup(32'h0500_0000, 32'h0100_0000, 16'd3, 16'd2, 16'd2, 5, -3);
        res_if.res_ready = 1'b1;
        push_points(32'h0500_0000, 32'h0100_0000, 1, 2, 5, -3);
        pulse_start();
        while (!seen && cyc < 50) begin
            if (res_if.res_valid && res_if.res_ready) begin
                check_handshake("rstmid");
                seen = 1'b1;
            end else begin
                @(negedge clk_in);
                cyc++;
            end
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL rstmid timeout: got no result, required point 0");
            sb.delete();
        end
        // TUNE, two SETTLE cycles, then one accepted sample of point 1
        repeat (5) @(negedge clk_in);
        n_vec++;
        if (busy !== 1'b1 || res_if.res_idx !== 16'd1 || res_if.res_I !== 28'sd5 ||
            Fre_word !== 32'h0600_0000) begin
            n_err++;
            $display("FAIL rstmid pre: got busy=%b idx=%0d I=%0d fre=%h required 1 1 5 06000000",
                     busy, res_if.res_idx, res_if.res_I, Fre_word);
        end
        #1 RST_n = 1'b0;
        #1 check_all_zero("rstmid");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            n_vec++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL rstmid hold[%0d]: got done=%b busy=%b required 0 0", k, done, busy);
            end
        end
        RST_n = 1'b1;
    endtask

    task automatic test_long();
        setup(32'h0000_1000, 32'h0, 16'd1, 16'd0, 16'd65535, -2048, 2047);
        push_points(32'h0000_1000, 32'h0, 1, 65535, -2048, 2047);
        n_vec++;
        if (sb[0].i !== -28'sd134215680) begin
            n_err++;
            $display("FAIL long model: got %0d required -134215680", sb[0].i);
        end
        pulse_start();
        run_and_check("long", 70000);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_npoints_zero();
        test_zero_len();
        test_abort();
        test_reset_mid();
        test_basic();
        test_long();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/iq_sweep_ctrl.md
IQ_SWEEP_CTRL -- requirements
Module: iq_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter PHASE_WIDTH, default 32, which sets the width of the frequency tuning word.
REQ-002 The block SHALL have parameter OUTPUT_WIDTH, default 12, which sets the width of the signed I/Q samples from the mixer.
REQ-003 The block SHALL have parameter CNT_WIDTH, default 16, which sets the width of the point, settle and acquisition counters.
REQ-004 The block SHALL have the following ports, each given as name, direction, width and meaning:
- clk_in, in, 1, the single clock.
- RST_n, in, 1, asynchronous active-low reset.
- start, in, 1, sweep request pulse.
- abort, in, 1, cancels the sweep.
- f_start, in, PHASE_WIDTH, first tuning word.
- f_step, in, PHASE_WIDTH, tuning-word increment per point.
- n_points, in, CNT_WIDTH, number of sweep points.
- settle_cyc, in, CNT_WIDTH, clk_in cycles to wait after each retune.
- acq_len, in, CNT_WIDTH, number of I/Q samples accumulated per point.
- Fre_word, out, PHASE_WIDTH, tuning word driven to the mixer.
- iq_valid, in, 1, strobe marking valid decimated mixer output.
- I_in, in, OUTPUT_WIDTH, signed I sample.
- Q_in, in, OUTPUT_WIDTH, signed Q sample.
- res_valid, out, 1, result valid.
- res_ready, in, 1, result accepted.
- res_I, out, OUTPUT_WIDTH+CNT_WIDTH, signed I sum.
- res_Q, out, OUTPUT_WIDTH+CNT_WIDTH, signed Q sum.
- res_idx, out, CNT_WIDTH, point index.
- busy, out, 1, sweep in progress.
- done, out, 1, one-cycle end-of-sweep pulse.

Function
REQ-005 The state machine SHALL have the states IDLE, TUNE, SETTLE, ACQ, REPORT and DONE.
REQ-006 In IDLE, start=1 with n_points!=0 SHALL latch f_start, f_step, n_points, settle_cyc and acq_len, clear the point index, and enter TUNE on the next edge.
- start with n_points=0 SHALL be ignored.
- start in any state other than IDLE SHALL be ignored.
REQ-007 TUNE SHALL last exactly one cycle.
- For point 0, TUNE loads Fre_word=f_start.
- For each later point, TUNE loads Fre_word=previous Fre_word+f_step, modulo 2^PHASE_WIDTH; wrap-around is silent.
- TUNE clears both accumulators and the sample counter, then enters SETTLE.
REQ-008 SETTLE SHALL count settle_cyc cycles and then enter ACQ; with settle_cyc=0 it lasts one cycle.
- iq_valid SHALL be ignored during TUNE and SETTLE.
REQ-009 In ACQ, each cycle with iq_valid=1 SHALL sign-extend I_in and Q_in into their accumulators and increment the sample counter.
- ACQ SHALL enter REPORT on the edge that accepts sample number max(acq_len,1); acq_len=0 is treated as 1.
REQ-010 The accumulators SHALL be OUTPUT_WIDTH+CNT_WIDTH bits signed two's complement and SHALL never overflow for acq_len up to 2^CNT_WIDTH-1.
REQ-011 In REPORT, res_valid SHALL be 1 and res_I, res_Q and res_idx SHALL hold stable until res_valid&res_ready is sampled.
- res_ready asserted early SHALL complete the handshake in the first REPORT cycle.
- res_ready held low SHALL keep REPORT indefinitely; samples arriving meanwhile are dropped.
REQ-012 On the handshake, the block SHALL enter DONE if res_idx==n_points-1; otherwise it SHALL increment the index and enter TUNE.
REQ-013 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-014 busy SHALL be 1 in every state except IDLE.
REQ-015 abort=1 in any state SHALL force IDLE on the next edge.
- res_valid SHALL deassert on that edge and done SHALL NOT pulse.
- Fre_word SHALL hold its last value.
- abort has priority over start and over the handshake when they occur in the same cycle.
REQ-016 Fre_word SHALL hold its value in every state except TUNE.
REQ-017 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.

Reset
REQ-018 Asserting RST_n=0 SHALL immediately, independent of clk_in, force the state machine to IDLE.
- Fre_word, res_I, res_Q, res_idx and all counters SHALL reset to 0.
- res_valid, busy and done SHALL reset to 0.
REQ-019 After RST_n deasserts, the first edge SHALL act as a normal IDLE cycle.
REQ-020 Reset asserted mid-sweep SHALL discard the sweep and SHALL NOT emit done.

Verification
REQ-021 The bench SHALL drive f_start=0x1000_0000, f_step=0x0100_0000, n_points=3, settle_cyc=4, acq_len=2, I_in=+5, Q_in=-3 with iq_valid held 1 and res_ready held 1.
- Required: results idx 0,1,2 each with res_I=10 and res_Q=-6.
- Required: Fre_word steps 0x1000_0000, 0x1100_0000, 0x1200_0000.
- Required: a single done pulse.
REQ-022 The bench SHALL drive f_start=0xFFFF_FF00, f_step=0x200, n_points=2.
- Required: the second Fre_word is 0x0000_0100 (wrap).
REQ-023 The bench SHALL hold res_ready=0 for 20 cycles in REPORT while I_in changes.
- Required: res_valid stays 1, outputs stay constant, and Fre_word does not change.
- Required: after res_ready rises, the next point proceeds.
REQ-024 The bench SHALL apply start with n_points=0, and separately acq_len=0 with settle_cyc=0.
- Required: n_points=0 leaves busy at 0.
- Required: acq_len=0, settle_cyc=0 gives results of one sample each.
REQ-025 The bench SHALL pulse abort during SETTLE, and separately pulse RST_n low during ACQ of point 1.
- Required for abort: IDLE next cycle, no done pulse, Fre_word unchanged.
- Required for reset: all outputs are 0 immediately, and a new start then runs normally.
REQ-026 The bench SHALL drive acq_len=65535 with I_in=-2048 on every sample.
- Required: res_I=-134215680 with no overflow.
